// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg - shared constants, Booth digit type and CSA-tree sizing helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

  localparam int MULT_W = 32;
  localparam int PROD_W = 64;

  // Radix-4 Booth group {b[2i+1], b[2i], b[2i-1]}
  typedef logic [2:0] booth_digit_t;

  // A level of 3:2 compressors turns every full group of three rows into two
  function automatic int rows_at(input int n, input int level);
    int r;
    r = n;
    for (int k = 0; k < level; k++) begin
      r = r - r / 3;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int n);
    int r;
    int k;
    r = n;
    k = 0;
    while (r > 2) begin
      r = r - r / 3;
      k++;
    end
    return k;
  endfunction

  function automatic int row_base(input int n, input int level);
    int s;
    s = 0;
    for (int k = 0; k < level; k++) begin
      s = s + rows_at(n, k);
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csa_3to2.sv
// ---------------------------------------------------------------------------
// csa_3to2 - bitwise full-adder row reducing three vectors to sum and carry
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum = x ^ y ^ z;

  // Carry out of the top bit is beyond the product width and is dropped
  assign carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};

endmodule

`default_nettype wire

// File: rtl/mult32_pipe.sv
// ---------------------------------------------------------------------------
// mult32_pipe - unsigned WIDTHxWIDTH multiplier, radix-4 Booth + CSA tree, registered product
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult32_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c
);

  localparam int PW     = 2 * WIDTH;
  localparam int NPP    = WIDTH / 2 + 1;
  localparam int NROWS  = NPP + 1;
  localparam int NLVL   = tree_levels(NROWS);
  localparam int NTOT   = row_base(NROWS, NLVL) + 2;
  localparam int FINAL  = row_base(NROWS, NLVL);

  // Two zero bits on top keep b unsigned; one zero below seeds the first group
  logic [WIDTH+2:0] b_pad;
  assign b_pad = {2'b00, b, 1'b0};

  logic [PW-1:0]  rows [NTOT];
  logic [NPP-1:0] negs;
  logic [PW-1:0]  neg_row;

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_digit_t   dig;
    logic [WIDTH:0] mag;
    logic           neg;
    logic [PW-1:0]  ext;

    assign dig = b_pad[2*i+2 -: 3];

    always_comb begin
      mag = '0;
      neg = 1'b0;
      case (dig)
        3'b001, 3'b010: begin mag = {1'b0, a}; neg = 1'b0; end
        3'b011:         begin mag = {a, 1'b0}; neg = 1'b0; end
        3'b100:         begin mag = {a, 1'b0}; neg = 1'b1; end
        3'b101, 3'b110: begin mag = {1'b0, a}; neg = 1'b1; end
        default:        begin mag = '0;        neg = 1'b0; end
      endcase
    end

    // One's complement here; the +1 lands in neg_row at the same weight
    assign ext     = {{(PW-WIDTH-1){1'b0}}, mag} ^ {PW{neg}};
    assign rows[i] = ext << (2 * i);
    assign negs[i] = neg;
  end

  always_comb begin
    neg_row = '0;
    for (int i = 0; i < NPP; i++) begin
      neg_row[2*i] = negs[i];
    end
  end

  assign rows[NPP] = neg_row;

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N    = rows_at(NROWS, l);
    localparam int BASE = row_base(NROWS, l);
    localparam int NB   = row_base(NROWS, l + 1);
    localparam int G    = N / 3;
    localparam int R    = N % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(PW)) u_csa (
        .x     (rows[BASE+3*g]),
        .y     (rows[BASE+3*g+1]),
        .z     (rows[BASE+3*g+2]),
        .sum   (rows[NB+2*g]),
        .carry (rows[NB+2*g+1])
      );
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign rows[NB+2*G+r] = rows[BASE+3*G+r];
    end
  end

  logic [PW-1:0] prod;
  assign prod = rows[FINAL] + rows[FINAL+1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
    end else begin
      c <= prod;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult32_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult32_pipe - randomized self-checking bench against a plain a*b model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult32_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] c;

  int n_cmp;
  int n_mis;

  mult32_pipe #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint unsigned xx;
    longint unsigned yy;
    xx = longint'(x);
    yy = longint'(y);
    return 64'(xx * yy);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a pair between edges, then check one edge later
  task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, c, ref_mul(x, y));
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] held;
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    a = '0;
    b = '0;

    // Reset held: outputs stay zero while operands toggle, even unknown ones
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      @(posedge clk);
      #1;
      check("reset_hold", c, 64'h0);
    end
    @(negedge clk);
    a = 'x;
    b = 'x;
    @(posedge clk);
    #1;
    check("reset_x_inputs", c, 64'h0);

    // Release and load the first product
    @(negedge clk);
    x = $urandom;
    y = $urandom;
    a = x;
    b = y;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", c, ref_mul(x, y));

    apply("basic_3x5", 32'd3, 32'd5);
    check("basic_15", c, 64'd15);
    apply("all_ones", 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("all_ones_const", c, 64'hFFFFFFFE00000001);
    apply("msb_x2", 32'h80000000, 32'h2);
    check("msb_x2_const", c, 64'h100000000);
    apply("zero_a", 32'h0, 32'hDEADBEEF);
    apply("zero_b", 32'hCAFEF00D, 32'h0);

    // Back-to-back, one pair per cycle
    apply("b2b_0", 32'd1, 32'd1);
    check("b2b_0_const", c, 64'd1);
    apply("b2b_1", 32'd2, 32'd3);
    check("b2b_1_const", c, 64'd6);
    apply("b2b_2", 32'h10000, 32'h10000);
    check("b2b_2_const", c, 64'h100000000);

    // Mid-cycle operand change must not disturb the registered product
    held = c;
    #2;
    a = 32'h12345678;
    b = 32'h9ABCDEF0;
    #1;
    check("midcycle_hold", c, held);

    // Random regression: each pair held for two edges
    for (int i = 0; i < 120; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 10 == 0) x = x | 32'h80000000;
      if (i % 10 == 5) y = y | 32'hAAAAAAAA;
      @(negedge clk);
      a = x;
      b = y;
      @(posedge clk);
      #1;
      check("rand_e1", c, ref_mul(x, y));
      @(posedge clk);
      #1;
      check("rand_e2", c, ref_mul(x, y));
    end

    // Asynchronous mid-run reset pulse
    apply("pre_reset", 32'h0F0F0F0F, 32'h33333333);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", c, 64'h0);
    @(posedge clk);
    #1;
    check("async_hold", c, 64'h0);
    @(negedge clk);
    x = $urandom;
    y = $urandom;
    a = x;
    b = y;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("resume", c, ref_mul(x, y));
    apply("resume_next", 32'h7FFFFFFF, 32'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
